// File: rtl/magnitude_frame_ctrl.sv
`timescale 1ns/1ps
// Frame sequencer for the gradient-magnitude stage: gates the magnitude unit, counts
// position and delays position/flag tags by PIPE_LAT. Optional macro: MAG_BORDER_FLAG_EN.
module magnitude_frame_ctrl #(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int PIPE_LAT = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic                       i_pix_valid,
  output logic                       o_mag_en,
  output logic                       o_out_valid,
  output logic [$clog2(IMG_W)-1:0]   o_col,
  output logic [$clog2(IMG_H)-1:0]   o_row,
  output logic                       o_sof,
  output logic                       o_eol,
  output logic                       o_eof,
  output logic                       o_border,
  output logic                       o_busy,
  output logic                       o_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          sof;
    logic          eol;
    logic          eof;
    logic          border;
  } tag_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          accept, last_col, last_row, drained;
  tag_t          tag_in;
  tag_t          tag_q [PIPE_LAT:1];
  logic [PIPE_LAT:1] vld_q;

  assign accept   = (state_q == RUN) && i_pix_valid;
  assign last_col = (col_q == CW'(IMG_W-1));
  assign last_row = (row_q == RW'(IMG_H-1));

  always_comb begin
    tag_in     = '0;
    tag_in.col = col_q;
    tag_in.row = row_q;
    tag_in.sof = (col_q == '0) && (row_q == '0);
    tag_in.eol = last_col;
    tag_in.eof = last_col && last_row;
`ifdef MAG_BORDER_FLAG_EN
    tag_in.border = (col_q == '0) || last_col || (row_q == '0) || last_row;
`else
    tag_in.border = 1'b0;
`endif
  end

  // The last stage is already on the outputs, so the frame is drained once
  // every earlier stage is empty; that puts o_done PIPE_LAT+1 after the last pixel.
  always_comb begin
    drained = 1'b1;
    for (int i = 1; i < PIPE_LAT; i++)
      if (vld_q[i]) drained = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    unique case (state_q)
      IDLE:  if (i_start) state_d = RUN;
      RUN:   if (accept) begin
               if (last_col) begin
                 col_d = '0;
                 if (last_row) begin
                   row_d   = '0;
                   state_d = DRAIN;
                 end else begin
                   row_d = row_q + 1'b1;
                 end
               end else begin
                 col_d = col_q + 1'b1;
               end
             end
      DRAIN: if (drained) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // Tag pipe advances every cycle; only the input stage depends on accept.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q <= '0;
      for (int i = 1; i <= PIPE_LAT; i++) tag_q[i] <= '0;
    end else begin
      vld_q[1] <= accept;
      tag_q[1] <= accept ? tag_in : '0;
      for (int i = 2; i <= PIPE_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign o_mag_en    = accept;
  assign o_out_valid = vld_q[PIPE_LAT];
  assign o_col       = tag_q[PIPE_LAT].col;
  assign o_row       = tag_q[PIPE_LAT].row;
  assign o_sof       = tag_q[PIPE_LAT].sof;
  assign o_eol       = tag_q[PIPE_LAT].eol;
  assign o_eof       = tag_q[PIPE_LAT].eof;
  assign o_border    = tag_q[PIPE_LAT].border;
  assign o_busy      = (state_q != IDLE);
  assign o_done      = (state_q == DONE);
endmodule
